// File: rtl/cpu_control.sv
// Multi-cycle control unit for a small LC-3 style core: IDLE/FETCH/DECODE/EXECUTE/HALTED.
// Build option: define CPU_CONTROL_BRANCH_EN to enable conditional branches (BR); otherwise BR is a NOP.
module cpu_control #(
  parameter logic [5:0] RESET_PC = 6'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  output logic [5:0]  imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  output logic [1:0]  alu_op,
  output logic [1:0]  source_sel,
  output logic [5:0]  ins_immediate,
  output logic [5:0]  pc,
  output logic [2:0]  sr1_sel,
  output logic [2:0]  sr2_sel,
  output logic [2:0]  dr_sel,
  output logic        reg_we,
  input  logic        alu_negative,
  input  logic        alu_zero,
  input  logic        alu_positive,
  output logic        halted
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_DECODE  = 3'd2;
  localparam logic [2:0] ST_EXECUTE = 3'd3;
  localparam logic [2:0] ST_HALTED  = 3'd4;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic [5:0]  pc_q;
  logic [15:0] ir;
  logic [2:0]  nzp;
  logic [1:0]  alu_op_q;
  logic [1:0]  source_sel_q;
  logic [2:0]  sr1_q;
  logic [2:0]  sr2_q;
  logic [2:0]  dr_q;

  logic [3:0]  opcode;
  logic        use_imm;
  logic        writes_reg;
  logic [1:0]  dec_alu_op;
  logic [1:0]  dec_source_sel;
  logic [5:0]  pc_exec_next;

  assign opcode  = ir[15:12];
  assign use_imm = ir[5];

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    dec_alu_op     = 2'b00;
    dec_source_sel = 2'b00;
    writes_reg     = 1'b0;
    case (opcode)
      OP_ADD: begin
        dec_alu_op     = 2'b00;
        dec_source_sel = {~use_imm, 1'b0};
        writes_reg     = 1'b1;
      end
      OP_AND: begin
        dec_alu_op     = 2'b01;
        dec_source_sel = {~use_imm, 1'b0};
        writes_reg     = 1'b1;
      end
      OP_NOT: begin
        dec_alu_op     = 2'b10;
        dec_source_sel = {~use_imm, 1'b0};
        writes_reg     = 1'b1;
      end
      OP_LEA: begin
        dec_alu_op     = 2'b00;
        dec_source_sel = 2'b01;
        writes_reg     = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef CPU_CONTROL_BRANCH_EN
  logic br_taken;
  assign br_taken     = (opcode == OP_BR) && ((ir[11:9] & nzp) != 3'b000);
  assign pc_exec_next = br_taken ? (pc_q + ir[5:0]) : pc_q;
`else
  // Without branches nothing consumes NZP; it stays as a visible debug register.
  logic unused_nzp;
  assign unused_nzp   = ^nzp;
  assign pc_exec_next = pc_q;
`endif

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (start) state_next = ST_FETCH;
      ST_FETCH:   if (imem_ready) state_next = ST_DECODE;
      ST_DECODE:  state_next = ST_EXECUTE;
      ST_EXECUTE: state_next = (opcode == OP_HALT) ? ST_HALTED : ST_FETCH;
      ST_HALTED:  state_next = ST_HALTED;
      default:    state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      pc_q         <= RESET_PC;
      ir           <= 16'h0000;
      nzp          <= 3'b010;
      alu_op_q     <= 2'b00;
      source_sel_q <= 2'b00;
      sr1_q        <= 3'd0;
      sr2_q        <= 3'd0;
      dr_q         <= 3'd0;
    end else begin
      state <= state_next;
      case (state)
        ST_FETCH: begin
          if (imem_ready) begin
            ir   <= imem_rdata;
            pc_q <= pc_q + 6'd1;
          end
        end
        ST_DECODE: begin
          alu_op_q     <= dec_alu_op;
          source_sel_q <= dec_source_sel;
          sr1_q        <= ir[8:6];
          sr2_q        <= ir[2:0];
          dr_q         <= ir[11:9];
        end
        ST_EXECUTE: begin
          if (writes_reg) nzp <= {alu_negative, alu_zero, alu_positive};
          pc_q <= pc_exec_next;
        end
        default: ;
      endcase
    end
  end

  assign imem_req      = (state == ST_FETCH);
  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign halted        = (state == ST_HALTED);
  assign alu_op        = alu_op_q;
  assign source_sel    = source_sel_q;
  assign sr1_sel       = sr1_q;
  assign sr2_sel       = sr2_q;
  assign dr_sel        = dr_q;
  assign ins_immediate = ir[5:0];
  // A reset arriving during EXECUTE suppresses the write on that same edge.
  assign reg_we        = rst_n && (state == ST_EXECUTE) && writes_reg;

endmodule

// File: tb/tb_cpu_control.sv
// Directed, table-driven bench for cpu_control; branch expectations follow CPU_CONTROL_BRANCH_EN.
module tb_cpu_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic [1:0]  alu_op;
  logic [1:0]  source_sel;
  logic [5:0]  ins_immediate;
  logic [5:0]  pc;
  logic [2:0]  sr1_sel;
  logic [2:0]  sr2_sel;
  logic [2:0]  dr_sel;
  logic        reg_we;
  logic        alu_negative;
  logic        alu_zero;
  logic        alu_positive;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_control #(.RESET_PC(6'd0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .alu_op(alu_op), .source_sel(source_sel), .ins_immediate(ins_immediate), .pc(pc),
    .sr1_sel(sr1_sel), .sr2_sel(sr2_sel), .dr_sel(dr_sel), .reg_we(reg_we),
    .alu_negative(alu_negative), .alu_zero(alu_zero), .alu_positive(alu_positive),
    .halted(halted)
  );

  typedef struct {
    logic [15:0] word;
    logic [2:0]  flags;
    logic [1:0]  exp_alu;
    logic [1:0]  exp_src;
    logic        exp_we;
    logic [2:0]  exp_dr;
    logic [2:0]  exp_sr1;
    logic [2:0]  exp_sr2;
    logic [5:0]  exp_imm;
  } vec_t;

  vec_t vecs[9];

  // Values captured by exec_instr.
  logic [5:0] pc_before, pc_exec, pc_after;
  logic       we_decode, we_exec, we_after, req_after;
  logic [1:0] cap_alu, cap_src;
  logic [2:0] cap_dr, cap_sr1, cap_sr2;
  logic [5:0] cap_imm;
  logic [2:0] tb_nzp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; imem_ready = 1'b0; imem_rdata = 16'h0000;
    {alu_negative, alu_zero, alu_positive} = 3'b000;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_req();
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (imem_req === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    check("wait_fetch_timeout", {31'd0, got}, 32'd1);
  endtask

  // Fetch one word with ready high, then step through DECODE and EXECUTE.
  task automatic exec_instr(input logic [15:0] word, input logic [2:0] flags);
    wait_req();
    pc_before  = pc;
    imem_rdata = word;
    imem_ready = 1'b1;
    {alu_negative, alu_zero, alu_positive} = flags;
    @(posedge clk); @(negedge clk);
    imem_ready = 1'b0;
    we_decode  = reg_we;
    @(posedge clk); @(negedge clk);
    we_exec = reg_we; pc_exec = pc;
    cap_alu = alu_op; cap_src = source_sel; cap_dr = dr_sel;
    cap_sr1 = sr1_sel; cap_sr2 = sr2_sel; cap_imm = ins_immediate;
    @(posedge clk); @(negedge clk);
    we_after = reg_we; req_after = imem_req; pc_after = pc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [5:0] exp_pc;
    logic [5:0] hold_pc;
    bit         halt_ok;

    vecs[0] = '{16'h1262, 3'b001, 2'b00, 2'b00, 1'b1, 3'd1, 3'd1, 3'd2, 6'd34};
    vecs[1] = '{16'h1242, 3'b010, 2'b00, 2'b10, 1'b1, 3'd1, 3'd1, 3'd2, 6'd2};
    vecs[2] = '{16'h5283, 3'b100, 2'b01, 2'b10, 1'b1, 3'd1, 3'd2, 3'd3, 6'd3};
    vecs[3] = '{16'h52BF, 3'b001, 2'b01, 2'b00, 1'b1, 3'd1, 3'd2, 3'd7, 6'd63};
    vecs[4] = '{16'h967F, 3'b010, 2'b10, 2'b00, 1'b1, 3'd3, 3'd1, 3'd7, 6'd63};
    vecs[5] = '{16'hE23F, 3'b100, 2'b00, 2'b01, 1'b1, 3'd1, 3'd0, 3'd7, 6'd63};
    vecs[6] = '{16'h9640, 3'b001, 2'b10, 2'b10, 1'b1, 3'd3, 3'd1, 3'd0, 6'd0};
    vecs[7] = '{16'h3ABC, 3'b100, 2'b00, 2'b00, 1'b0, 3'd5, 3'd2, 3'd4, 6'd60};
    vecs[8] = '{16'h0005, 3'b010, 2'b00, 2'b00, 1'b0, 3'd0, 3'd0, 3'd5, 6'd5};

    // Reset state
    @(negedge clk);
    do_reset();
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_pc", {26'd0, pc}, 32'd0);
    check("rst_imem_addr", {26'd0, imem_addr}, 32'd0);
    check("rst_outs", {alu_op, source_sel, ins_immediate, sr1_sel, sr2_sel, dr_sel, reg_we, halted},
          32'd0);
    check("rst_nzp", {29'd0, dut.nzp}, 32'd2);
    repeat (3) @(negedge clk);
    check("idle_no_start", {31'd0, imem_req}, 32'd0);

    // Reset mid-fetch with ready high: no pc update
    pulse_start();
    check("fetch_req", {31'd0, imem_req}, 32'd1);
    imem_ready = 1'b1; imem_rdata = 16'h1242; rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    check("midfetch_rst_pc", {26'd0, pc}, 32'd0);
    check("midfetch_rst_req", {31'd0, imem_req}, 32'd0);
    rst_n = 1'b1; imem_ready = 1'b0;

    // Stall in FETCH for 5 cycles; start held high is ignored
    pulse_start();
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("stall_req", {31'd0, imem_req}, 32'd1);
      check("stall_pc", {26'd0, pc}, 32'd0);
      @(negedge clk);
    end
    start = 1'b0;

    // Table of single instructions
    tb_nzp = 3'b010;
    for (int i = 0; i < 9; i++) begin
      exec_instr(vecs[i].word, vecs[i].flags);
      if (vecs[i].exp_we) tb_nzp = vecs[i].flags;
      check($sformatf("vec%0d_decode", i),
            {8'd0, cap_alu, cap_src, cap_dr, cap_sr1, cap_sr2, cap_imm},
            {8'd0, vecs[i].exp_alu, vecs[i].exp_src, vecs[i].exp_dr, vecs[i].exp_sr1,
             vecs[i].exp_sr2, vecs[i].exp_imm});
      check($sformatf("vec%0d_we", i), {29'd0, we_decode, we_exec, we_after},
            {29'd0, 1'b0, vecs[i].exp_we, 1'b0});
      check($sformatf("vec%0d_pc", i), {26'd0, pc_exec}, {26'd0, 6'(i + 1)});
      check($sformatf("vec%0d_refetch", i), {31'd0, req_after}, 32'd1);
      check($sformatf("vec%0d_nzp", i), {29'd0, dut.nzp}, {29'd0, tb_nzp});
    end

    // ADD sets Z, then BR z #4 at pc 10
    exec_instr(16'h1242, 3'b010);
    check("br_setup_pc", {26'd0, pc_after}, 32'd10);
    exec_instr(16'h0404, 3'b100);
`ifdef CPU_CONTROL_BRANCH_EN
    exp_pc = 6'd15;
`else
    exp_pc = 6'd11;
`endif
    check("br_z_taken_pc", {26'd0, pc_after}, {26'd0, exp_pc});
    check("br_keeps_nzp", {29'd0, dut.nzp}, 32'd2);
    check("br_no_we", {31'd0, we_exec}, 32'd0);
    exec_instr(16'h0804, 3'b000);
    check("br_n_not_taken_pc", {26'd0, pc_after}, {26'd0, pc_before + 6'd1});
    exec_instr(16'h1242, 3'b100);
    exec_instr(16'h0804, 3'b001);
`ifdef CPU_CONTROL_BRANCH_EN
    exp_pc = pc_before + 6'd5;
`else
    exp_pc = pc_before + 6'd1;
`endif
    check("br_n_taken_pc", {26'd0, pc_after}, {26'd0, exp_pc});

    // Walk pc to 63 with NOPs, then wrap
    for (int i = 0; i < 64 && pc != 6'd63; i++) exec_instr(16'h2000, 3'b000);
    check("walk_to_63", {26'd0, pc}, 32'd63);
    exec_instr(16'h2000, 3'b000);
    check("pc_wrap", {26'd0, pc_after}, 32'd0);

    // HALT holds forever, start ignored
    exec_instr(16'hF000, 3'b000);
    check("halt_we", {31'd0, we_exec}, 32'd0);
    check("halt_flag", {31'd0, halted}, 32'd1);
    check("halt_req", {31'd0, req_after}, 32'd0);
    hold_pc = pc;
    halt_ok = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!(halted === 1'b1 && imem_req === 1'b0 && reg_we === 1'b0 && pc === hold_pc))
        halt_ok = 1'b0;
    end
    start = 1'b0;
    check("halt_holds", {31'd0, halt_ok}, 32'd1);

    // Reset during EXECUTE of an ADD
    do_reset();
    pulse_start();
    wait_req();
    imem_rdata = 16'h1242; imem_ready = 1'b1;
    {alu_negative, alu_zero, alu_positive} = 3'b100;
    @(posedge clk); @(negedge clk);
    imem_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    check("exec_we_before_rst", {31'd0, reg_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("exec_rst_no_we", {31'd0, reg_we}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("exec_rst_idle", {31'd0, imem_req}, 32'd0);
    check("exec_rst_pc", {26'd0, pc}, 32'd0);
    check("exec_rst_nzp", {29'd0, dut.nzp}, 32'd2);
    check("exec_rst_outs", {alu_op, source_sel, dr_sel, reg_we, halted}, 32'd0);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
